inv_key_schedule: RTL and testbench
===================================

# inv_key_schedule

Iterative inverse AES-128 key schedule for the decryption path. Loads the round-10 key and walks the schedule backwards, one key step per accepted handshake. It presents round keys 10, 9, …, 0 in the order the inverse-cipher round datapath consumes them. It is the counterpart of the forward next-round-key logic, reusing the same Rcon, RotWord and SubWord primitives.

## Interface
Parameters:
- BYTE, 8, byte width
- WORD, 32, word width
- SENTENCE, 128, key/state width

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  load request; honoured only in IDLE
- last_Round_Key  input  SENTENCE  round-10 key; sampled on an accepted start
- round_Key  output  SENTENCE  current round key
- round_Number  output  4  round index of round_Key (10 down to 0)
- key_Valid  output  1  round_Key/round_Number are valid
- key_Ready  input  1  consumer accepts the current key
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after round 0 is accepted

## Operation
- Word order: w0 = [SENTENCE-1:3*WORD] … w3 = [WORD-1:0]. The same order is used in the forward schedule.
- Rcon(i), i=1..10: 01,02,04,08,10,20,40,80,1b,36 in the MSB byte, lower 24 bits zero. Key i is derived from key i-1 with Rcon(i), so the inverse step from key i uses Rcon(i).
- Inverse step, from next key n0..n3 at round i to previous key p0..p3:
  - p3 = n3^n2
  - p2 = n2^n1
  - p1 = n1^n0
  - p0 = n0 ^ SubWord(RotWord(p3)) ^ Rcon(i)
- FSM, two states:
  - IDLE: key_Valid=0, busy=0. On start=1, load last_Round_Key into the key register, set round_Number=10, go to RUN.
  - RUN: key_Valid=1, busy=1. On key_Valid&key_Ready:
    - if round_Number==0: go to IDLE and pulse done.
    - otherwise: key register <= inverse step, round_Number <= round_Number-1.
- With no handshake, round_Key and round_Number hold stable. They must not change while key_Valid=1 and key_Ready=0.
- start in RUN is ignored; it neither restarts nor queues.
- start and done coincide only when start is asserted in the cycle done is high. The block is already in IDLE that cycle, so the start is accepted normally.
- round_Number never leaves 0..10. The decrement saturates structurally, because the step is never taken at 0.

## Timing
- Reset values: round_Key=0, round_Number=0, key_Valid=0, busy=0, done=0, FSM=IDLE.
- rst mid-operation: next cycle is IDLE with all outputs at reset values; the key in progress is discarded.
- Latency: start sampled at cycle t → key_Valid=1, round 10 at t+1.
- Throughput: one key per cycle. With key_Ready held high, rounds 10..0 appear on cycles t+1..t+11, done=1 at t+12, key_Valid=0 at t+12.
- Earliest accepted restart: start at t+12 gives round 10 at t+13.
- The inverse step is a single-cycle combinational path (S-box lookup plus XORs) into the key register; no pipelining.

## Configuration
- INV_KEY_ZEROIZE_EN defined: on the done cycle the key register clears to 0, so round_Key=0 and round_Number=0 in IDLE after a walk.
- INV_KEY_ZEROIZE_EN undefined: round_Key holds the round-0 (cipher) key in IDLE until the next start or rst.
- rst clears the register to 0 in both builds.

## Structure
- Shared package:
  - SENTENCE/WORD/BYTE constants
  - 4-bit round-index type
  - Rcon table constants
  - FSM state enum (IDLE, RUN)
  - S-box table, shared with the forward path
- Sub-module inv_key_step: purely combinational n→p inverse step. It instantiates the existing Rcon, RotWord and SubWord modules. The top holds only the FSM, key register and round counter.

## Test plan
- FIPS-197 A.1 walk: last_Round_Key = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, key_Ready=1.
  - Round 10 equals the input.
  - Round 9 = ac7766f3 19fadc21 28d12941 575c006e.
  - Round 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c at t+11; done at t+12.
- Backpressure: key_Ready=0 for 5 cycles at round 7. round_Key and round_Number=7 stay stable, key_Valid stays 1. Resuming completes with identical keys.
- start pulsed at rounds 10, 5 and 0 during RUN: no effect on the sequence; exactly one done pulse.
- rst asserted at round 4: next cycle all outputs are 0 and FSM is IDLE. A fresh start replays the full A.1 sequence.
- Round-trip: feed each produced key i-1 through the forward next-round-key logic with Rcon(i); the output equals key i for all i=1..10. Repeat with random 128-bit keys.
- Build with and without INV_KEY_ZEROIZE_EN: after done, round_Key = 0 with the macro, and = 2b7e1516… without it.

Source files
------------

// File: rtl/inv_key_schedule_pkg.sv
// ---------------------------------------------------------------------------
// inv_key_schedule_pkg
// Shared AES-128 key-schedule definitions used by the forward and inverse
// key paths: width constants, round-index type, Rcon table, FSM state
// encodings for the inverse schedule, and the AES S-box.
// No ports (package).
// ---------------------------------------------------------------------------
package inv_key_schedule_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 32;
    localparam int SENTENCE_W = 128;

    typedef logic [3:0] round_idx_t;

    localparam round_idx_t LAST_ROUND = 4'd10;

    // Inverse-schedule FSM encodings
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    // Rcon MSB byte indexed by round; entries outside 1..10 are zero
    localparam logic [7:0] RCON_TABLE [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/inv_key_schedule_step.sv
// ---------------------------------------------------------------------------
// Key-schedule primitives and the combinational inverse AES-128 key step.
//   Rcon        : round_i (4b) -> rcon_o (WORD), Rcon byte in the MSBs
//   RotWord     : word_i -> word_o, one-byte left rotation
//   SubWord     : word_i -> word_o, S-box applied per byte
//   inv_key_step: next_key_i (key i), round_i (i) -> prev_key_o (key i-1)
// Word order: w0 = [SENTENCE-1 -: WORD] ... w3 = [WORD-1:0].
// ---------------------------------------------------------------------------
module Rcon
    import inv_key_schedule_pkg::*;
#(
    parameter int BYTE = BYTE_W,
    parameter int WORD = WORD_W
) (
    input  round_idx_t      round_i,
    output logic [WORD-1:0] rcon_o
);
    assign rcon_o = {RCON_TABLE[round_i], {(WORD-BYTE){1'b0}}};
endmodule

module RotWord #(
    parameter int BYTE = 8,
    parameter int WORD = 32
) (
    input  logic [WORD-1:0] word_i,
    output logic [WORD-1:0] word_o
);
    assign word_o = {word_i[WORD-BYTE-1:0], word_i[WORD-1 -: BYTE]};
endmodule

module SubWord
    import inv_key_schedule_pkg::*;
#(
    parameter int BYTE = BYTE_W,
    parameter int WORD = WORD_W
) (
    input  logic [WORD-1:0] word_i,
    output logic [WORD-1:0] word_o
);
    for (genvar i = 0; i < WORD/BYTE; i++) begin : g_byte
        assign word_o[i*BYTE +: BYTE] = sbox_lookup(word_i[i*BYTE +: BYTE]);
    end
endmodule

module inv_key_step
    import inv_key_schedule_pkg::*;
#(
    parameter int BYTE     = BYTE_W,
    parameter int WORD     = WORD_W,
    parameter int SENTENCE = SENTENCE_W
) (
    input  logic [SENTENCE-1:0] next_key_i,
    input  round_idx_t          round_i,
    output logic [SENTENCE-1:0] prev_key_o
);
    logic [WORD-1:0] n0, n1, n2, n3;
    logic [WORD-1:0] p0, p1, p2, p3;
    logic [WORD-1:0] rot, sub, rcon;

    assign n0 = next_key_i[SENTENCE-1 -: WORD];
    assign n1 = next_key_i[SENTENCE-WORD-1 -: WORD];
    assign n2 = next_key_i[SENTENCE-2*WORD-1 -: WORD];
    assign n3 = next_key_i[WORD-1:0];

    assign p3 = n3 ^ n2;
    assign p2 = n2 ^ n1;
    assign p1 = n1 ^ n0;

    // p3 is recovered first because the forward step derived n0 from it
    RotWord #(.BYTE(BYTE), .WORD(WORD)) u_rot (.word_i(p3),  .word_o(rot));
    SubWord #(.BYTE(BYTE), .WORD(WORD)) u_sub (.word_i(rot), .word_o(sub));
    Rcon    #(.BYTE(BYTE), .WORD(WORD)) u_rcon (.round_i(round_i), .rcon_o(rcon));

    assign p0 = n0 ^ sub ^ rcon;

    assign prev_key_o = {p0, p1, p2, p3};
endmodule

// File: rtl/inv_key_schedule.sv
// ---------------------------------------------------------------------------
// inv_key_schedule
// Iterative inverse AES-128 key schedule. Loads the round-10 key on start
// and presents round keys 10..0, stepping back one key per accepted
// key_Valid/key_Ready handshake.
// Ports:
//   clk, rst (sync, active high)
//   start          : load request, honoured only in IDLE
//   last_Round_Key : round-10 key, sampled on an accepted start
//   round_Key      : current round key
//   round_Number   : index of round_Key (10..0)
//   key_Valid      : round_Key/round_Number valid (RUN)
//   key_Ready      : consumer accepts the current key
//   busy           : high in RUN
//   done           : one-cycle pulse after round 0 is accepted
// Build option: INV_KEY_ZEROIZE_EN clears the key register on the done cycle;
// otherwise the round-0 key is held in IDLE until the next start or rst.
// ---------------------------------------------------------------------------
module inv_key_schedule
    import inv_key_schedule_pkg::*;
#(
    parameter int BYTE     = BYTE_W,
    parameter int WORD     = WORD_W,
    parameter int SENTENCE = SENTENCE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SENTENCE-1:0] last_Round_Key,
    output logic [SENTENCE-1:0] round_Key,
    output logic [3:0]          round_Number,
    output logic                key_Valid,
    input  logic                key_Ready,
    output logic                busy,
    output logic                done
);
    state_t              state_q, state_d;
    logic [SENTENCE-1:0] key_q, key_d;
    round_idx_t          round_q, round_d;
    logic                done_q, done_d;
    logic [SENTENCE-1:0] prev_key;

    inv_key_step #(
        .BYTE    (BYTE),
        .WORD    (WORD),
        .SENTENCE(SENTENCE)
    ) u_step (
        .next_key_i(key_q),
        .round_i   (round_q),
        .prev_key_o(prev_key)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = last_Round_Key;
                    round_d = LAST_ROUND;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (key_Ready) begin
                    // No step at round 0, so round_q cannot wrap below 0
                    if (round_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
`ifdef INV_KEY_ZEROIZE_EN
                        key_d   = '0;
`endif
                    end else begin
                        key_d   = prev_key;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign round_Key    = key_q;
    assign round_Number = round_q;
    assign key_Valid    = (state_q == RUN);
    assign busy         = (state_q == RUN);
    assign done         = done_q;
endmodule

// File: tb/tb_inv_key_schedule.sv
module tb_inv_key_schedule;
    import inv_key_schedule_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] last_Round_Key;
    logic [127:0] round_Key;
    logic [3:0]   round_Number;
    logic         key_Valid;
    logic         key_Ready;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    inv_key_schedule dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .last_Round_Key(last_Round_Key),
        .round_Key     (round_Key),
        .round_Number  (round_Number),
        .key_Valid     (key_Valid),
        .key_Ready     (key_Ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // FIPS-197 A.1 expanded keys, index = round
    localparam logic [127:0] K [11] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };

`ifdef INV_KEY_ZEROIZE_EN
    localparam logic [127:0] KIDLE = '0;
`else
    localparam logic [127:0] KIDLE = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
`endif

    typedef struct {
        logic         start;
        logic         ready;
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         valid;
        logic         done;
    } vec_t;

    vec_t         vt [24];
    logic [127:0] cap [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic r, input int rnd,
                                input logic [127:0] k, input logic v, input logic d);
        vec_t x;
        x.start = s;
        x.ready = r;
        x.rnd   = 4'(rnd);
        x.key   = k;
        x.valid = v;
        x.done  = d;
        return x;
    endfunction

    function automatic logic [7:0] rc(input int r);
        case (r)
            1:  return 8'h01;
            2:  return 8'h02;
            3:  return 8'h04;
            4:  return 8'h08;
            5:  return 8'h10;
            6:  return 8'h20;
            7:  return 8'h40;
            8:  return 8'h80;
            9:  return 8'h1b;
            10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Forward AES-128 next-round-key
    function automatic logic [127:0] fwd(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox_lookup(t[31:24]), sbox_lookup(t[23:16]),
              sbox_lookup(t[15:8]),  sbox_lookup(t[7:0])};
        t  = t ^ {rc(r), 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Full walk with key_Ready=1, capturing keys 10..0 into cap[]
    task automatic walk(input logic [127:0] lk, input string tag);
        last_Round_Key = lk;
        start = 1'b1;
        key_Ready = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            cap[r] = round_Key;
            check($sformatf("%s.rnd%0d", tag, r), 128'(round_Number), 128'(r));
            tick();
        end
        check({tag, ".done"}, 128'(done), 128'd1);
    endtask

    task automatic wait_round(input int r, input string tag);
        for (int c = 0; c < 20 && !(key_Valid && round_Number == 4'(r)); c++) tick();
        check({tag, ".reach"}, 128'(round_Number), 128'(r));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int dones;
        int exp_r;
        logic [127:0] lk;

        vt[0] = mk(1, 1, 10, K[10], 1, 0);
        for (int k = 1; k <= 10; k++) vt[k] = mk(0, 1, 10 - k, K[10 - k], 1, 0);
        vt[11] = mk(0, 1, 0, KIDLE, 0, 1);
        vt[12] = mk(1, 0, 10, K[10], 1, 0);    // restart in the done cycle
        for (int k = 1; k <= 10; k++) vt[12 + k] = mk(0, 1, 10 - k, K[10 - k], 1, 0);
        vt[23] = mk(0, 1, 0, KIDLE, 0, 1);

        rst = 1'b1;
        start = 1'b0;
        key_Ready = 1'b0;
        last_Round_Key = K[10];
        tick();
        tick();
        rst = 1'b0;
        check("reset.key",   round_Key, '0);
        check("reset.rnd",   128'(round_Number), '0);
        check("reset.valid", 128'(key_Valid), '0);
        check("reset.busy",  128'(busy), '0);
        check("reset.done",  128'(done), '0);

        // A.1 walk, done, immediate restart, second walk
        for (int i = 0; i < 24; i++) begin
            start = vt[i].start;
            key_Ready = vt[i].ready;
            tick();
            check($sformatf("vec%0d.key", i),   round_Key, vt[i].key);
            check($sformatf("vec%0d.rnd", i),   128'(round_Number), 128'(vt[i].rnd));
            check($sformatf("vec%0d.valid", i), 128'(key_Valid), 128'(vt[i].valid));
            check($sformatf("vec%0d.busy", i),  128'(busy), 128'(vt[i].valid));
            check($sformatf("vec%0d.done", i),  128'(done), 128'(vt[i].done));
        end
        start = 1'b0;
        key_Ready = 1'b0;
        tick();
        check("idle.done", 128'(done), '0);
        check("idle.key",  round_Key, KIDLE);
        check("idle.rnd",  128'(round_Number), '0);

        // Backpressure at round 7
        start = 1'b1;
        key_Ready = 1'b1;
        tick();
        start = 1'b0;
        wait_round(7, "bp");
        key_Ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp.hold%0d.rnd", c),   128'(round_Number), 128'd7);
            check($sformatf("bp.hold%0d.key", c),   round_Key, K[7]);
            check($sformatf("bp.hold%0d.valid", c), 128'(key_Valid), 128'd1);
        end
        key_Ready = 1'b1;
        for (int r = 6; r >= 0; r--) begin
            tick();
            check($sformatf("bp.key%0d", r), round_Key, K[r]);
        end
        tick();
        check("bp.done", 128'(done), 128'd1);

        // start pulses at rounds 10, 5 and 0 while running
        start = 1'b1;
        key_Ready = 1'b1;
        tick();
        dones = 0;
        exp_r = 10;
        for (int c = 0; c < 20; c++) begin
            if (key_Valid) begin
                check($sformatf("sp.rnd%0d", exp_r), 128'(round_Number), 128'(exp_r));
                check($sformatf("sp.key%0d", exp_r), round_Key, K[exp_r < 0 ? 0 : exp_r]);
                exp_r--;
            end
            start = key_Valid && (round_Number == 4'd10 || round_Number == 4'd5 ||
                                  round_Number == 4'd0);
            tick();
            if (done) dones++;
        end
        start = 1'b0;
        check("sp.count", 128'(exp_r), 128'(-1));
        check("sp.dones", 128'(dones), 128'd1);
        check("sp.idle",  128'(key_Valid), '0);

        // rst at round 4, then fresh replay
        start = 1'b1;
        key_Ready = 1'b1;
        tick();
        start = 1'b0;
        wait_round(4, "rst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        key_Ready = 1'b0;
        check("rst.key",   round_Key, '0);
        check("rst.rnd",   128'(round_Number), '0);
        check("rst.valid", 128'(key_Valid), '0);
        check("rst.busy",  128'(busy), '0);
        check("rst.done",  128'(done), '0);
        tick();
        check("rst.stay_idle", 128'(key_Valid), '0);
        walk(K[10], "replay");
        for (int r = 0; r <= 10; r++) check($sformatf("replay.key%0d", r), cap[r], K[r]);
        key_Ready = 1'b0;
        tick();
        check("replay.idle_key", round_Key, KIDLE);

        // Round-trip through the forward schedule, A.1 then random keys
        for (int t = 0; t < 4; t++) begin
            lk = (t == 0) ? K[10] : {$urandom, $urandom, $urandom, $urandom};
            walk(lk, $sformatf("rt%0d", t));
            check($sformatf("rt%0d.k10", t), cap[10], lk);
            for (int i = 1; i <= 10; i++)
                check($sformatf("rt%0d.fwd%0d", t, i), fwd(cap[i - 1], i), cap[i]);
            key_Ready = 1'b0;
            tick();
`ifdef INV_KEY_ZEROIZE_EN
            check($sformatf("rt%0d.idle_key", t), round_Key, '0);
`else
            check($sformatf("rt%0d.idle_key", t), round_Key, cap[0]);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
